// File: rtl/div_unsigned_nbit_pkg.sv
// Shared definitions for the unsigned restoring divider: FSM state encodings.
package div_unsigned_nbit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_unsigned_nbit.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// A zero divisor takes a single BUSY cycle and returns quotient = all ones,
// remainder = dividend, error = 1 (RISC-V DIVU/REMU behaviour).
module div_unsigned_nbit
    import div_unsigned_nbit_pkg::*;
#(
    parameter int SIZE = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            ready,
    output logic            valid,
    output logic            error,
    input  logic [SIZE-1:0] dividend,
    input  logic [SIZE-1:0] divisor,
    output logic [SIZE-1:0] quotient,
    output logic [SIZE-1:0] remainder
);

    localparam int CNT_W = $clog2(SIZE + 1);

    div_state_e       state_q, state_d;
    // Working registers: dvd_q shifts dividend bits out of the top while
    // quotient bits shift in at the bottom.
    logic [SIZE-1:0]  dvd_q, dvd_d;
    logic [SIZE-1:0]  dvs_q, dvs_d;
    logic [SIZE-1:0]  rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // Output registers, held between DONE cycles.
    logic [SIZE-1:0]  quo_out_q, quo_out_d;
    logic [SIZE-1:0]  rem_out_q, rem_out_d;
    logic             err_q, err_d;

    // Trial step: the partial remainder is SIZE+1 bits wide only transiently;
    // after the conditional subtract it is always below the divisor.
    logic [SIZE:0]    trial;
    logic             fits;
    logic [SIZE-1:0]  diff;

    assign trial = {rem_q, dvd_q[SIZE-1]};
    assign fits  = (trial >= {1'b0, dvs_q});
    assign diff  = trial[SIZE-1:0] - dvs_q;

    // Register update for control, working and output state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            quo_out_q <= '0;
            rem_out_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            quo_out_q <= quo_out_d;
            rem_out_q <= rem_out_d;
            err_q     <= err_d;
        end
    end

    // Next-state logic: capture on acceptance, iterate MSB first, publish on the last step.
    always_comb begin
        state_d   = state_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        quo_out_d = quo_out_q;
        rem_out_d = rem_out_q;
        err_d     = err_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    dvd_d   = dividend;
                    dvs_d   = divisor;
                    rem_d   = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (dvs_q == '0) begin
                    quo_out_d = '1;
                    rem_out_d = dvd_q;
                    err_d     = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    rem_d = fits ? diff : trial[SIZE-1:0];
                    dvd_d = {dvd_q[SIZE-2:0], fits};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(SIZE - 1)) begin
                        quo_out_d = dvd_d;
                        rem_out_d = rem_d;
                        state_d   = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign ready     = (state_q == ST_IDLE);
    assign valid     = (state_q == ST_DONE);
    assign error     = err_q;
    assign quotient  = quo_out_q;
    assign remainder = rem_out_q;

endmodule

// File: tb/tb_div_unsigned_nbit.sv
// Scoreboard bench for div_unsigned_nbit: a 32-bit instance with directed and
// random back-to-back traffic, and an 8-bit instance with random traffic.
module tb_div_unsigned_nbit;

    localparam int WA = 32;
    localparam int WB = 8;
    localparam int NRAND_A = 1200;
    localparam int NRAND_B = 2000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_na = 1'b1;
    logic          start_a = 1'b0;
    logic          ready_a, valid_a, error_a;
    logic [WA-1:0] dvd_a = '0, dvs_a = '0, quo_a, rem_a;

    logic          rst_nb = 1'b1;
    logic          start_b = 1'b0;
    logic          ready_b, valid_b, error_b;
    logic [WB-1:0] dvd_b = '0, dvs_b = '0, quo_b, rem_b;

    div_unsigned_nbit #(.SIZE(WA)) dut_a (
        .clk(clk), .rst_n(rst_na), .start(start_a), .ready(ready_a), .valid(valid_a),
        .error(error_a), .dividend(dvd_a), .divisor(dvs_a), .quotient(quo_a), .remainder(rem_a)
    );

    div_unsigned_nbit #(.SIZE(WB)) dut_b (
        .clk(clk), .rst_n(rst_nb), .start(start_b), .ready(ready_b), .valid(valid_b),
        .error(error_b), .dividend(dvd_b), .divisor(dvs_b), .quotient(quo_b), .remainder(rem_b)
    );

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        e;
        int          cyc;
    } exp_t;

    exp_t sb_a[$];
    exp_t sb_b[$];
    exp_t ea, eb;

    int chk_cnt = 0;
    int pass_cnt = 0;
    int cyc = 0;
    int acc_a = 0, vld_a = 0, acc_b = 0, vld_b = 0;
    bit done_b = 1'b0;
    logic [WA-1:0] held_qa = '0, held_ra = '0;
    logic [WB-1:0] held_qb = '0, held_rb = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference model: plain unsigned division with the zero-divisor rule.
    task automatic model(input logic [31:0] a, input logic [31:0] b, input int w,
                         output logic [31:0] q, output logic [31:0] r, output logic e);
        logic [31:0] ones;
        ones = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        if (b == 0) begin
            q = ones; r = a; e = 1'b1;
        end else begin
            q = a / b; r = a % b; e = 1'b0;
        end
    endtask

    task automatic issue_a(input logic [31:0] a, input logic [31:0] b, input logic [31:0] eq,
                           input logic [31:0] er, input logic ee, input bit hold, input bit push);
        int n;
        n = 0;
        @(negedge clk);
        while (!ready_a) begin
            n++;
            if (n > 200) begin
                $display("FAIL a_ready_timeout: ready low for %0d cycles, expected 1", n);
                $fatal(1, "ready timeout");
            end
            @(negedge clk);
        end
        dvd_a = a; dvs_a = b; start_a = 1'b1;
        if (push) begin
            sb_a.push_back('{eq, er, ee, cyc + 1 + ((b == 0) ? 1 : WA)});
            acc_a++;
        end
        @(posedge clk); #1;
        if (!hold) start_a = 1'b0;
    endtask

    task automatic issue_b(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q, r;
        logic e;
        int n;
        model(a, b, WB, q, r, e);
        n = 0;
        @(negedge clk);
        while (!ready_b) begin
            n++;
            if (n > 100) begin
                $display("FAIL b_ready_timeout: ready low for %0d cycles, expected 1", n);
                $fatal(1, "ready timeout");
            end
            @(negedge clk);
        end
        dvd_b = a[WB-1:0]; dvs_b = b[WB-1:0]; start_b = 1'b1;
        sb_b.push_back('{q, r, e, cyc + 1 + ((b == 0) ? 1 : WB)});
        acc_b++;
        @(posedge clk); #1;
    endtask

    task automatic wait_idle_a();
        int n;
        n = 0;
        @(negedge clk);
        while (sb_a.size() != 0 || !ready_a) begin
            n++;
            if (n > 200) begin
                $display("FAIL a_drain_timeout: %0d results outstanding, expected 0", sb_a.size());
                $fatal(1, "drain timeout");
            end
            @(negedge clk);
        end
    endtask

    // Monitor for the 32-bit instance.
    initial begin
        forever begin
            @(negedge clk);
            check("a_ready_valid_excl", ready_a & valid_a, 0);
            if (!rst_na) begin
                held_qa = '0; held_ra = '0;
            end else if (valid_a) begin
                vld_a++;
                if (sb_a.size() == 0) begin
                    chk_cnt++;
                    $display("FAIL a_unexpected_valid: valid=1 with no pending op, expected 0");
                end else begin
                    ea = sb_a.pop_front();
                    check("a_quotient", quo_a, ea.q);
                    check("a_remainder", rem_a, ea.r);
                    check("a_error", error_a, ea.e);
                    check("a_latency_cycle", cyc, ea.cyc);
                end
                held_qa = quo_a; held_ra = rem_a;
            end else begin
                check("a_quotient_hold", quo_a, held_qa);
                check("a_remainder_hold", rem_a, held_ra);
                if (!ready_a) check("a_error_clear_busy", error_a, 0);
            end
        end
    end

    // Monitor for the 8-bit instance.
    initial begin
        forever begin
            @(negedge clk);
            check("b_ready_valid_excl", ready_b & valid_b, 0);
            if (!rst_nb) begin
                held_qb = '0; held_rb = '0;
            end else if (valid_b) begin
                vld_b++;
                if (sb_b.size() == 0) begin
                    chk_cnt++;
                    $display("FAIL b_unexpected_valid: valid=1 with no pending op, expected 0");
                end else begin
                    eb = sb_b.pop_front();
                    check("b_quotient", quo_b, eb.q);
                    check("b_remainder", rem_b, eb.r);
                    check("b_error", error_b, eb.e);
                    check("b_latency_cycle", cyc, eb.cyc);
                end
                held_qb = quo_b; held_rb = rem_b;
            end else begin
                check("b_quotient_hold", quo_b, held_qb);
                check("b_remainder_hold", rem_b, held_rb);
            end
        end
    end

    // 8-bit stimulus: random operands, start held high back-to-back.
    initial begin
        logic [31:0] a, b;
        int n;
        #1 rst_nb = 1'b0;
        #30 rst_nb = 1'b1;
        for (int i = 0; i < NRAND_B; i++) begin
            a = $urandom_range(0, 255);
            case ($urandom_range(0, 7))
                0:       b = 0;
                1:       b = 1;
                2:       b = $urandom_range(2, 7);
                3:       b = 255;
                default: b = $urandom_range(1, 255);
            endcase
            issue_b(a, b);
        end
        start_b = 1'b0;
        n = 0;
        while (sb_b.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        done_b = 1'b1;
    end

    // 32-bit stimulus: reset checks, directed cases, then random back-to-back.
    initial begin
        logic [31:0] a, b, q, r;
        logic e;
        int bad, n;

        #1 rst_na = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", ready_a, 1);
        check("rst_valid", valid_a, 0);
        check("rst_error", error_a, 0);
        check("rst_quotient", quo_a, 0);
        check("rst_remainder", rem_a, 0);
        #2 rst_na = 1'b1;

        issue_a(100, 7, 14, 2, 0, 0, 1);
        bad = 0;
        repeat (WA) begin
            @(negedge clk);
            if (ready_a) bad++;
        end
        check("ready_low_while_busy", bad, 0);
        wait_idle_a();

        issue_a(32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 0, 0, 0, 1);
        wait_idle_a();
        issue_a(5, 9, 0, 5, 0, 0, 1);
        wait_idle_a();
        issue_a(32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000, 0, 0, 1);
        wait_idle_a();

        issue_a(1234, 0, 32'hFFFF_FFFF, 1234, 1, 0, 1);
        wait_idle_a();
        issue_a(10, 3, 3, 1, 0, 0, 1);
        wait_idle_a();

        // Operands scrambled and start toggled while busy must not disturb the op.
        issue_a(1000000, 37, 27027, 1, 0, 0, 1);
        repeat (20) begin
            @(negedge clk);
            dvd_a = $urandom; dvs_a = $urandom; start_a = 1'($urandom_range(0, 1));
        end
        start_a = 1'b0;
        wait_idle_a();

        // Reset in the middle of an operation aborts it with no valid pulse.
        issue_a(1000, 3, 0, 0, 0, 0, 0);
        repeat (10) @(negedge clk);
        #2 rst_na = 1'b0;
        #1;
        check("midrst_ready", ready_a, 1);
        check("midrst_valid", valid_a, 0);
        check("midrst_quotient", quo_a, 0);
        check("midrst_remainder", rem_a, 0);
        check("midrst_error", error_a, 0);
        @(negedge clk);
        #2 rst_na = 1'b1;
        repeat (WA + 5) @(negedge clk);
        issue_a(9, 3, 3, 0, 0, 0, 1);
        wait_idle_a();

        for (int i = 0; i < NRAND_A; i++) begin
            case ($urandom_range(0, 5))
                0:       a = 32'hFFFF_FFFF;
                1:       a = $urandom_range(0, 20);
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       b = 0;
                1:       b = 1;
                2:       b = $urandom_range(2, 15);
                3:       b = a + $urandom_range(1, 100);
                4:       b = 32'hFFFF_FFFF;
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            model(a, b, WA, q, r, e);
            issue_a(a, b, q, r, e, 1, 1);
        end
        start_a = 1'b0;
        wait_idle_a();

        n = 0;
        while (!done_b && n < 50000) begin
            @(negedge clk);
            n++;
        end
        check("b_finished", done_b, 1);
        check("a_one_valid_per_start", vld_a, acc_a);
        check("b_one_valid_per_start", vld_b, acc_b);
        check("b_queue_empty", sb_b.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
